key_debounce_n: RTL and testbench



---
 rtl/key_pkg.sv | 12 +
 rtl/key_chan.sv | 111 +++++++++++
 rtl/key_debounce_n.sv | 57 +++++
 tb/tb_key_debounce_n.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared constants and helpers for the key conditioning blocks.
package key_pkg;

    // Sample tick of 10 ms from a 100 MHz clock.
    localparam int KEY_TICK_10MS_100MHZ = 1000000;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int key_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_chan.sv
// One key channel: synchroniser, polarity fix, stable-count debouncer,
// press/release pulses and optional hold-to-repeat pulses.
module key_chan
    import key_pkg::*;
#(
    parameter int ACTIVE_LOW = 0,
    parameter int STABLE_SMP = 3,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    input  logic tick,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_repeat
);

    localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
    localparam int   SW       = key_width(STABLE_SMP - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_SMP - 1);

    logic          sync1;
    logic          sync2;
    logic          sample;
    logic [SW-1:0] stable_cnt;
    logic          flip;

    // NOTE: every clocked block uses non-blocking assignments so all flops
    // update together on the edge and sync2 really sees last cycle's sync1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= IDLE_LVL;
            sync2 <= IDLE_LVL;
        end else begin
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    assign sample = sync2 ^ IDLE_LVL;

    // Deciding tick: enough consecutive samples disagree with the current level.
    assign flip = tick && (sample != key_state) && (stable_cnt == S_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_cnt  <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= flip && !key_state;
            key_release <= flip && key_state;
            if (tick) begin
                if (sample == key_state) begin
                    stable_cnt <= '0;
                end else if (flip) begin
                    key_state  <= sample;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 1'b1;
                end
            end
        end
    end

    generate
        if (REPEAT_DLY > 0) begin : g_rep
            localparam int HMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
            localparam int HW   = key_width(HMAX);

            logic [HW-1:0] hold_cnt;
            logic [HW-1:0] hold_nxt;
            logic [HW-1:0] hold_tgt;
            logic          armed;

            // Before the first repeat the target is the initial delay, then the period;
            // the count restarts at each repeat so it stays bounded.
            assign hold_nxt = hold_cnt + 1'b1;
            assign hold_tgt = armed ? HW'(REPEAT_PER) : HW'(REPEAT_DLY);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_cnt   <= '0;
                    armed      <= 1'b0;
                    key_repeat <= 1'b0;
                end else begin
                    key_repeat <= 1'b0;
                    if (!key_state || key_press) begin
                        hold_cnt <= '0;
                        armed    <= 1'b0;
                    end else if (tick && !flip) begin
                        if (hold_nxt == hold_tgt) begin
                            key_repeat <= 1'b1;
                            hold_cnt   <= '0;
                            armed      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_nxt;
                        end
                    end
                end
            end
        end else begin : g_no_rep
            assign key_repeat = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/key_debounce_n.sv
// N-channel push-button conditioner; one shared sample-tick divider drives
// all key_chan instances.
module key_debounce_n
    import key_pkg::*;
#(
    parameter int N_KEYS     = 3,
    parameter int TICK_DIV   = KEY_TICK_10MS_100MHZ,
    parameter int STABLE_SMP = 3,
    parameter int ACTIVE_LOW = 0,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int TW = key_width(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
            key_chan #(
                .ACTIVE_LOW (ACTIVE_LOW),
                .STABLE_SMP (STABLE_SMP),
                .REPEAT_DLY (REPEAT_DLY),
                .REPEAT_PER (REPEAT_PER)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .key_in      (key_in[g]),
                .tick        (tick),
                .key_state   (key_state[g]),
                .key_press   (key_press[g]),
                .key_release (key_release[g]),
                .key_repeat  (key_repeat[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_key_debounce_n.sv
// Bench for key_debounce_n: three builds (active-high, active-low, no repeat)
// checked every cycle against a sample-history model plus literal expectations.
module tb_key_debounce_n;

    localparam int N   = 3;
    localparam int TD  = 4;
    localparam int S   = 3;
    localparam int PER = 2;
    localparam int NI  = 3;
    localparam int AL_P  [NI] = '{0, 1, 0};
    localparam int DLY_P [NI] = '{5, 5, 0};

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] kin     [NI];
    logic [N-1:0] d_state [NI];
    logic [N-1:0] d_press [NI];
    logic [N-1:0] d_rel   [NI];
    logic [N-1:0] d_rep   [NI];

    int checks   = 0;
    int failures = 0;
    int phase    = 0;
    int u1_ev    = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            key_debounce_n #(
                .N_KEYS     (N),
                .TICK_DIV   (TD),
                .STABLE_SMP (S),
                .ACTIVE_LOW (AL_P[g]),
                .REPEAT_DLY (DLY_P[g]),
                .REPEAT_PER (PER)
            ) u_dut (
                .clk         (clk),
                .rst         (rst),
                .key_in      (kin[g]),
                .key_state   (d_state[g]),
                .key_press   (d_press[g]),
                .key_release (d_rel[g]),
                .key_repeat  (d_rep[g])
            );
        end
    endgenerate

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference model: pin delay line, history of the last S tick samples,
    // and a count of held ticks since the press.
    bit m_h1    [NI][N];
    bit m_h2    [NI][N];
    bit m_state [NI][N];
    bit m_press [NI][N];
    bit m_rel   [NI][N];
    bit m_rep   [NI][N];
    bit m_smp   [NI][N][S];
    int m_nsmp  [NI][N];
    int m_hold  [NI][N];
    int m_cyc;
    bit m_tick;
    bit m_s;
    bit m_dec;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_cyc = 0;
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < N; k++) begin
                    m_h1[i][k]    = (AL_P[i] != 0);
                    m_h2[i][k]    = (AL_P[i] != 0);
                    m_state[i][k] = 1'b0;
                    m_press[i][k] = 1'b0;
                    m_rel[i][k]   = 1'b0;
                    m_rep[i][k]   = 1'b0;
                    m_nsmp[i][k]  = 0;
                    m_hold[i][k]  = 0;
                end
            end
        end else begin
            m_tick = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < N; k++) begin
                    m_s = m_h2[i][k] ^ (AL_P[i] != 0);
                    m_h2[i][k] = m_h1[i][k];
                    m_h1[i][k] = kin[i][k];
                    m_press[i][k] = 1'b0;
                    m_rel[i][k]   = 1'b0;
                    m_rep[i][k]   = 1'b0;
                    if (m_tick) begin
                        for (int j = S - 1; j > 0; j--) m_smp[i][k][j] = m_smp[i][k][j-1];
                        m_smp[i][k][0] = m_s;
                        if (m_nsmp[i][k] < S) m_nsmp[i][k]++;
                        m_dec = (m_nsmp[i][k] == S);
                        for (int j = 0; j < S; j++)
                            if (m_smp[i][k][j] == m_state[i][k]) m_dec = 1'b0;
                        if (m_state[i][k] && !m_dec) begin
                            m_hold[i][k]++;
                            if (DLY_P[i] > 0 && m_hold[i][k] >= DLY_P[i] &&
                                ((m_hold[i][k] - DLY_P[i]) % PER) == 0)
                                m_rep[i][k] = 1'b1;
                        end
                        if (m_dec) begin
                            m_state[i][k] = !m_state[i][k];
                            m_press[i][k] = m_state[i][k];
                            m_rel[i][k]   = !m_state[i][k];
                            m_hold[i][k]  = 0;
                        end
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison of every build against the model.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            logic [4*N-1:0] ev;
            for (int k = 0; k < N; k++) begin
                ev[3*N+k] = m_state[i][k];
                ev[2*N+k] = m_press[i][k];
                ev[N+k]   = m_rel[i][k];
                ev[k]     = m_rep[i][k];
            end
            check($sformatf("model_dut%0d", i),
                  32'({d_state[i], d_press[i], d_rel[i], d_rep[i]}), 32'(ev));
        end
        if (phase < 5) u1_ev += int'(|{d_state[1], d_press[1], d_rel[1], d_rep[1]});
    end

    int cd [NI][N];

    initial begin
        int n_ev;
        int tp;
        int r1;
        int r2;
        int tr;
        int late;
        int np;
        int nr;
        int rst_hold;

        kin[0] = 3'b111;
        kin[1] = 3'b111;
        kin[2] = 3'b000;
        rst = 1'b0;
        #1 rst = 1'b1;

        // Test 1: pins pressed through reset, press after exactly 3 ticks
        repeat (3) step();
        check("reset_outputs", 32'({d_state[0], d_press[0], d_rel[0], d_rep[0]}), 32'd0);
        rst = 1'b0;
        phase = 1;
        repeat (11) step();
        check("t1_state_before", 32'(d_state[0]), 32'd0);
        step();
        check("t1_press", 32'(d_press[0]), 32'b111);
        check("t1_state", 32'(d_state[0]), 32'b111);
        step();
        check("t1_press_end", 32'(d_press[0]), 32'd0);
        n_ev = 0;
        repeat (40) begin
            step();
            n_ev += int'(|d_press[0]);
        end
        check("t1_no_more_press", 32'(n_ev), 32'd0);
        kin[0] = 3'b000;
        repeat (60) step();

        // Test 2: toggling every 5 cycles never qualifies
        phase = 2;
        n_ev = 0;
        for (int c = 0; c < 80; c++) begin
            if (c % 5 == 0) kin[0][0] = ~kin[0][0];
            step();
            n_ev += int'(d_state[0][0] | d_press[0][0] | d_rel[0][0]);
        end
        check("t2_bounce_no_event", 32'(n_ev), 32'd0);
        kin[0][0] = 1'b0;
        repeat (40) step();

        // Test 3: long hold with repeats, then release
        phase = 3;
        tp = -1; r1 = -1; r2 = -1; tr = -1; late = 0;
        kin[0][2] = 1'b1;
        for (int c = 0; c < 80; c++) begin
            step();
            if (d_press[0][2]) tp = c;
            if (d_rep[0][2]) begin
                if (r1 < 0) r1 = c;
                else if (r2 < 0) r2 = c;
            end
        end
        kin[0][2] = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (d_rel[0][2]) tr = c;
            if (tr >= 0 && d_rep[0][2]) late++;
        end
        check("t3_press_latency_ok", 32'(tp >= 10 && tp <= 13), 32'd1);
        check("t3_first_repeat_gap", 32'(r1 - tp), 32'd20);
        check("t3_next_repeat_gap", 32'(r2 - r1), 32'd8);
        check("t3_release_latency_ok", 32'(tr >= 10 && tr <= 13), 32'd1);
        check("t3_no_repeat_after_release", 32'(late), 32'd0);
        repeat (20) step();

        // Test 4: reset mid-qualification requires a fresh 3-tick run
        phase = 4;
        n_ev = 0;
        kin[0][1] = 1'b1;
        repeat (8) begin
            step();
            n_ev += int'(d_press[0][1] | d_state[0][1]);
        end
        check("t4_no_early_press", 32'(n_ev), 32'd0);
        rst = 1'b1;
        repeat (3) step();
        check("t4_in_reset", 32'({d_state[0], d_press[0]}), 32'd0);
        rst = 1'b0;
        tp = -1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (d_press[0][1]) tp = c;
        end
        check("t4_press_after_reset", 32'(tp), 32'd11);
        kin[0] = 3'b000;
        repeat (40) step();

        // Test 5: active-low build
        check("t5_idle_no_events", 32'(u1_ev), 32'd0);
        phase = 5;
        tp = -1;
        kin[1][1] = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (d_press[1][1]) tp = c;
        end
        check("t5_al_press_latency_ok", 32'(tp >= 10 && tp <= 13), 32'd1);
        check("t5_al_state", 32'(d_state[1]), 32'b010);
        kin[1] = 3'b111;
        repeat (40) step();

        // Test 6: repeat disabled
        phase = 6;
        np = 0; nr = 0;
        kin[2][0] = 1'b1;
        repeat (120) begin
            step();
            np += int'(d_press[2][0]);
            nr += int'(d_rep[2][0]);
        end
        check("t6_single_press", 32'(np), 32'd1);
        check("t6_no_repeat", 32'(nr), 32'd0);
        kin[2] = 3'b000;
        repeat (40) step();

        // Random holds and bounces on every build, with occasional resets
        phase = 7;
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < N; k++) cd[i][k] = $urandom_range(1, 40);
        rst_hold = 0;
        for (int c = 0; c < 6000; c++) begin
            step();
            for (int i = 0; i < NI; i++) begin
                for (int k = 0; k < N; k++) begin
                    cd[i][k]--;
                    if (cd[i][k] <= 0) begin
                        kin[i][k] = ~kin[i][k];
                        cd[i][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6)
                                                               : $urandom_range(8, 120);
                    end
                end
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst = 1'b0;
            end else if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b1;
                rst_hold = 2;
            end
        end
        rst = 1'b0;
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
